// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS pipeline stages: skid-buffer state encoding,
// the default-width WB payload and the hard-wired zero register index.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;

    localparam int unsigned ZERO_REG = 0;

    // Field order here is the packing order used by every WB stage.
    typedef struct packed {
        logic                          reg_wr;
        logic                          mem2reg;
        logic [DEF_REG_ADDR_WIDTH-1:0] write_reg;
        logic [DEF_DATA_WIDTH-1:0]     result;
    } wb_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// Handshake: a beat moves when valid & ready are both high on a rising edge;
// in_ready_o depends only on registered state, so downstream stalls never
// reach the upstream combinationally.
module pipe_skid_buf
    import mips_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output skid_state_t  state_o
);

    skid_state_t  state_q;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         drain;

    assign in_ready_o  = (state_q != ST_FULL) && !reset;
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_q;
    assign state_o     = state_q;

    assign accept = in_valid_i && in_ready_o;
    assign drain  = out_valid_o && out_ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush_i) begin
            // Data is left stale; only the state marks the entries dead.
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q  <= in_data_i;
                        state_q <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_q <= in_data_i;
                    end else if (accept) begin
                        skid_q  <= in_data_i;
                        state_q <= ST_FULL;
                    end else if (drain) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        main_q  <= skid_q;
                        state_q <= ST_ONE;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/wb_elastic_pipe_reg.sv
// MEM->WB elastic pipeline register: result select and r0 gating at capture,
// 2-entry skid buffer for backpressure. Optional stall counter: WB_STALL_CNT_EN.
module wb_elastic_pipe_reg
    import mips_pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      reg_wr_m,
    input  logic                      mem2reg_m,
    input  logic [DATA_WIDTH-1:0]     data_m,
    input  logic [REG_ADDR_WIDTH-1:0] write_reg_m,
    input  logic [DATA_WIDTH-1:0]     alu_result_m,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      reg_wr_w,
    output logic                      mem2reg_w,
    output logic [REG_ADDR_WIDTH-1:0] write_reg_w,
    output logic [DATA_WIDTH-1:0]     result_w,
`ifdef WB_STALL_CNT_EN
    output logic [CNT_WIDTH-1:0]      stall_cnt,
`endif
    output skid_state_t               dbg_state
);

    typedef struct packed {
        logic                      reg_wr;
        logic                      mem2reg;
        logic [REG_ADDR_WIDTH-1:0] write_reg;
        logic [DATA_WIDTH-1:0]     result;
    } payload_t;

    payload_t cap_d;
    payload_t main_view;

    // Result is selected before the flop so result_w is a direct flop output.
    always_comb begin
        cap_d           = '0;
        cap_d.reg_wr    = reg_wr_m && (write_reg_m != REG_ADDR_WIDTH'(ZERO_REG));
        cap_d.mem2reg   = mem2reg_m;
        cap_d.write_reg = write_reg_m;
        cap_d.result    = mem2reg_m ? data_m : alu_result_m;
    end

    pipe_skid_buf #(
        .W($bits(payload_t))
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (cap_d),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (main_view),
        .state_o    (dbg_state)
    );

    assign reg_wr_w    = main_view.reg_wr && out_valid;
    assign mem2reg_w   = main_view.mem2reg;
    assign write_reg_w = main_view.write_reg;
    assign result_w    = main_view.result;

`ifdef WB_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;

    // Saturating; flush deliberately leaves the count alone.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_elastic_pipe_reg.sv
// Self-checking bench for wb_elastic_pipe_reg: directed cases plus a random
// stream, checked against an expected-payload queue.
module tb_wb_elastic_pipe_reg;
    import mips_pipe_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int PW = 2 + RW + DW;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          reg_wr_m;
    logic          mem2reg_m;
    logic [DW-1:0] data_m;
    logic [RW-1:0] write_reg_m;
    logic [DW-1:0] alu_result_m;
    logic          out_valid;
    logic          out_ready;
    logic          reg_wr_w;
    logic          mem2reg_w;
    logic [RW-1:0] write_reg_w;
    logic [DW-1:0] result_w;
`ifdef WB_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif
    skid_state_t   dbg_state;

    wb_elastic_pipe_reg #(
        .DATA_WIDTH    (DW),
        .REG_ADDR_WIDTH(RW),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .reg_wr_m    (reg_wr_m),
        .mem2reg_m   (mem2reg_m),
        .data_m      (data_m),
        .write_reg_m (write_reg_m),
        .alu_result_m(alu_result_m),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .reg_wr_w    (reg_wr_w),
        .mem2reg_w   (mem2reg_w),
        .write_reg_w (write_reg_w),
        .result_w    (result_w),
`ifdef WB_STALL_CNT_EN
        .stall_cnt   (stall_cnt),
`endif
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            n_checks;
    int            n_errors;
    logic [PW-1:0] exp_q[$];
    logic          last_accept;
    logic          hold_pending;
    logic [PW-1:0] held;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic rw, input logic m2r,
                                            input logic [RW-1:0] wreg,
                                            input logic [DW-1:0] dat,
                                            input logic [DW-1:0] alu);
        logic          wr;
        logic [DW-1:0] res;
        wr  = rw && (wreg != '0);
        res = m2r ? dat : alu;
        return {wr, m2r, wreg, res};
    endfunction

    function automatic logic [PW-1:0] obs_vec();
        return {reg_wr_w, mem2reg_w, write_reg_w, result_w};
    endfunction

    // Sample on the falling edge, then advance past the next rising edge.
    task automatic tick();
        logic [PW-1:0] e;
        @(negedge clk);
        last_accept = in_valid && in_ready;
        if (reset || flush) begin
            exp_q.delete();
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", {63'd0, out_valid}, 64'd1);
                check("hold_stable", 64'(obs_vec()), 64'(held));
            end
            if (!out_valid) check("wr_gated", {63'd0, reg_wr_w}, 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_drain", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("drain", 64'(obs_vec()), 64'(e));
                end
            end
            if (last_accept) exp_q.push_back(model(reg_wr_m, mem2reg_m, write_reg_m, data_m, alu_result_m));
            hold_pending = out_valid && !out_ready;
            held         = obs_vec();
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic rw, input logic m2r, input logic [RW-1:0] wreg,
                          input logic [DW-1:0] dat, input logic [DW-1:0] alu);
        reg_wr_m     = rw;
        mem2reg_m    = m2r;
        write_reg_m  = wreg;
        data_m       = dat;
        alu_result_m = alu;
    endtask

    task automatic send(input logic rw, input logic m2r, input logic [RW-1:0] wreg,
                        input logic [DW-1:0] dat, input logic [DW-1:0] alu);
        int n;
        set_in(rw, m2r, wreg, dat, alu);
        in_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_accept && n < 50);
        in_valid = 1'b0;
        if (!last_accept) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain_all();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        n_checks     = 0;
        n_errors     = 0;
        hold_pending = 1'b0;
        last_accept  = 1'b0;
        held         = '0;
        reset        = 1'b1;
        flush        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        set_in(1'b0, 1'b0, '0, '0, '0);

        // Reset held for two cycles
        tick();
        tick();
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_outputs", 64'(obs_vec()), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Single load, latency 1
        out_ready = 1'b1;
        send(1'b1, 1'b1, 5'd8, 32'hDEADBEEF, 32'h1234);
        check("load_valid", {63'd0, out_valid}, 64'd1);
        check("load_result", 64'(result_w), 64'hDEADBEEF);
        check("load_wreg", 64'(write_reg_w), 64'd8);
        check("load_wr", {63'd0, reg_wr_w}, 64'd1);
        drain_all();

        // Backpressure: A, B fill the buffer, C waits
        out_ready = 1'b0;
        send(1'b1, 1'b0, 5'd3, 32'hFFFF, 32'd1);
        send(1'b1, 1'b0, 5'd4, 32'hFFFF, 32'd2);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_state", 64'(dbg_state), 64'(ST_FULL));
        set_in(1'b1, 1'b0, 5'd5, 32'hFFFF, 32'd3);
        in_valid = 1'b1;
        repeat (3) tick();
        check("bp_hold_a", 64'(result_w), 64'd1);
        check("bp_c_blocked", {63'd0, last_accept}, 64'd0);
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            do begin
                tick();
                n++;
            end while (!last_accept && n < 20);
            if (!last_accept) check("bp_c_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
        drain_all();

        // Write to r0 is suppressed, data still delivered
        send(1'b1, 1'b0, 5'd0, 32'hAAAA, 32'd5);
        check("r0_valid", {63'd0, out_valid}, 64'd1);
        check("r0_wr", {63'd0, reg_wr_w}, 64'd0);
        check("r0_result", 64'(result_w), 64'd5);
        drain_all();

        // Flush from FULL with a valid input in the same cycle
        out_ready = 1'b0;
        send(1'b1, 1'b0, 5'd6, 32'd0, 32'h11);
        send(1'b1, 1'b0, 5'd7, 32'd0, 32'h22);
        check("fl_state_full", 64'(dbg_state), 64'(ST_FULL));
        set_in(1'b1, 1'b0, 5'd9, 32'd0, 32'h33);
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", {63'd0, out_valid}, 64'd0);
        check("fl_state_empty", 64'(dbg_state), 64'(ST_EMPTY));
        out_ready = 1'b1;
        repeat (3) tick();

        // Random stream with random backpressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   RW'($urandom_range(0, 31)), $urandom, $urandom);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            tick();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        drain_all();

        // Reset mid-operation discards held entries
        out_ready = 1'b0;
        send(1'b1, 1'b1, 5'd10, 32'hBEEF, 32'd0);
        send(1'b1, 1'b1, 5'd11, 32'hCAFE, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_outputs", 64'(obs_vec()), 64'd0);
        out_ready = 1'b1;
        repeat (3) tick();

`ifdef WB_STALL_CNT_EN
        // Stall counter saturation, flush immunity, reset clear
        out_ready = 1'b0;
        send(1'b1, 1'b0, 5'd12, 32'd0, 32'h77);
        repeat (20) tick();
        check("cnt_sat", 64'(stall_cnt), 64'd15);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("cnt_flush", 64'(stall_cnt), 64'd15);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("cnt_reset", 64'(stall_cnt), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
